// File: rtl/hash_pkg.sv
// hash_pkg: shared encodings for the SHA-2 K+W round sequencer (mode, round counts, FSM states)
package hash_pkg;
  typedef enum logic {MODE_256 = 1'b0, MODE_512 = 1'b1} mode_t;
  localparam int ROUNDS_256 = 64;
  localparam int ROUNDS_512 = 80;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/hash_kw_seq_if.sv
// hash_kw_seq_if: K+W output stream to the compression datapath
//   kw       K+W sum at stream head
//   kw_vld   head valid
//   kw_rdy   downstream accepts head
//   kw_first head is round 0
//   kw_last  head is final round
interface hash_kw_seq_if #(parameter int WW = 64);
  logic [WW-1:0] kw;
  logic kw_vld;
  logic kw_rdy;
  logic kw_first;
  logic kw_last;
  modport master(output kw, kw_vld, kw_first, kw_last, input kw_rdy);
  modport slave(input kw, kw_vld, kw_first, kw_last, output kw_rdy);
endinterface

// File: rtl/kw_skid_fifo.sv
// kw_skid_fifo: shift-register sync FIFO whose head entry is always a register
//   clk, rst  clock and synchronous active-high reset
//   flush     empties the FIFO next cycle
//   push/din  write an entry (caller guarantees space)
//   pop       consume head (caller guarantees non-empty)
//   dout      head entry, zero when empty
//   cnt       occupancy
//   vld       non-empty
module kw_skid_fifo #(
  parameter int DW = 66,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  logic pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [CW-1:0] cnt,
  output logic vld
);
  logic [DW-1:0] mem [DEPTH];
  assign vld = cnt != '0;
  assign dout = vld ? mem[0] : '0;
  // entries shift toward slot 0 on pop; a push lands just past the surviving entries
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      cnt <= cnt + CW'(push) - CW'(pop);
      for (int i = 0; i < DEPTH; i++)
        if (push && i == int'(cnt) - int'(pop)) mem[i] <= din;
        else if (pop && i < DEPTH - 1) mem[i] <= mem[i < DEPTH - 1 ? i + 1 : i];
    end
  end
endmodule

// File: rtl/hash_kw_seq.sv
// hash_kw_seq: SHA-2 round sequencer streaming K+W sums (64 rounds/32-bit or 80 rounds/64-bit)
//   clk, rst        clock and synchronous active-high reset
//   h_clr           flush / abort
//   h_run, h_mode   start a block in IDLE; mode 0 = 32-bit/64 rounds, 1 = 64-bit/80 rounds
//   w, w_vld, k     schedule word, its valid, round constant for the current round
//   round           round index to K ROM / W scheduler
//   round_adv       current round consumed this cycle
//   kw_bus          K+W output stream (master)
//   kw_done         one-cycle pulse after final transfer
//   busy            not IDLE
//   run_err         pulse: h_run rejected outside IDLE
module hash_kw_seq import hash_pkg::*; #(
  parameter int WW = 64,
  parameter int RW = 7,
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic h_clr,
  input  logic h_run,
  input  logic h_mode,
  input  logic [WW-1:0] w,
  input  logic w_vld,
  input  logic [WW-1:0] k,
  output logic [RW-1:0] round,
  output logic round_adv,
  hash_kw_seq_if.master kw_bus,
  output logic kw_done,
  output logic busy,
  output logic run_err
);
  localparam int CW = $clog2(DEPTH + 1);
  state_t state;
  mode_t mode;
  logic [CW-1:0] cnt;
  logic pop, space, last_rnd;
  logic [31:0] sum32;
  logic [WW-1:0] sum;
  logic [WW+1:0] head;
  assign sum32 = k[31:0] + w[31:0];
  assign sum = mode == MODE_512 ? k + w : WW'(sum32);
  assign last_rnd = round == RW'((mode == MODE_512 ? ROUNDS_512 : ROUNDS_256) - 1);
  assign pop = kw_bus.kw_vld && kw_bus.kw_rdy;
  // a full FIFO still has room when its head leaves this cycle
  assign space = int'(cnt) < DEPTH || pop;
  assign round_adv = !rst && !h_clr && state == RUN && w_vld && space;
  assign busy = state != IDLE;
  assign {kw_bus.kw, kw_bus.kw_first, kw_bus.kw_last} = head;
  kw_skid_fifo #(.DW(WW + 2), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(h_clr),
    .push(round_adv),
    .pop(pop),
    .din({sum, round == '0, last_rnd}),
    .dout(head),
    .cnt(cnt),
    .vld(kw_bus.kw_vld)
  );
  always_ff @(posedge clk) begin
    if (rst || h_clr) begin
      state <= IDLE;
      mode <= MODE_256;
      round <= '0;
      kw_done <= 1'b0;
      run_err <= 1'b0;
    end else begin
      kw_done <= 1'b0;
      run_err <= h_run && state != IDLE;
      case (state)
        IDLE: if (h_run) begin
          mode <= mode_t'(h_mode);
          round <= '0;
          state <= RUN;
        end
        RUN: if (round_adv) begin
          round <= last_rnd ? '0 : round + 1'b1;
          if (last_rnd) state <= DRAIN;
        end
        DRAIN: if (pop && cnt == CW'(1)) begin
          state <= DONE;
          kw_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hash_kw_seq.sv
// tb_hash_kw_seq: randomized self-checking bench for the K+W round sequencer
module tb_hash_kw_seq;
  localparam int WW = 64, RW = 7, DEPTH = 2;
  logic clk = 1'b0, rst = 1'b1, h_clr = 1'b0, h_run = 1'b0, h_mode = 1'b0, w_vld = 1'b0;
  logic [WW-1:0] w, k;
  logic [RW-1:0] round;
  logic round_adv, kw_done, busy, run_err;
  logic [WW-1:0] ktab [0:127];
  logic [WW-1:0] wtab [0:127];
  int checks = 0, failures = 0, cyc = 0;
  bit vld_rand = 1'b0, rdy_tog = 1'b0;
  logic [WW-1:0] q_kw [$];
  bit q_first [$], q_last [$];
  int q_cyc [$];
  int adv_cnt = 0, done_cnt = 0, done_cyc = -1, err_cnt = 0;

  hash_kw_seq_if #(.WW(WW)) kwb();
  hash_kw_seq #(.WW(WW), .RW(RW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .h_clr(h_clr), .h_run(h_run), .h_mode(h_mode),
    .w(w), .w_vld(w_vld), .k(k), .round(round), .round_adv(round_adv),
    .kw_bus(kwb), .kw_done(kw_done), .busy(busy), .run_err(run_err)
  );

  assign k = ktab[round];
  assign w = wtab[round];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (kwb.kw_vld && kwb.kw_rdy) begin
      q_kw.push_back(kwb.kw);
      q_first.push_back(kwb.kw_first);
      q_last.push_back(kwb.kw_last);
      q_cyc.push_back(cyc);
    end
    if (round_adv) adv_cnt++;
    if (kw_done) begin done_cnt++; done_cyc = cyc; end
    if (run_err) err_cnt++;
  end

  initial forever begin
    @(posedge clk); #1;
    if (vld_rand) w_vld = 1'($urandom_range(0, 1));
    if (rdy_tog) kwb.kw_rdy = !kwb.kw_rdy;
  end

  // reference: the sum the compression unit must see for round i
  function automatic logic [WW-1:0] model(bit m, int i);
    logic [31:0] s;
    s = ktab[i][31:0] + wtab[i][31:0];
    return m ? ktab[i] + wtab[i] : {32'h0, s};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic fill_count();
    for (int i = 0; i < 128; i++) begin ktab[i] = 64'(i); wtab[i] = 64'd1; end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 128; i++) begin ktab[i] = {$urandom, $urandom}; wtab[i] = {$urandom, $urandom}; end
  endtask

  task automatic start(input bit m, output int t);
    t = cyc; h_run = 1'b1; h_mode = m;
    tick();
    h_run = 1'b0;
  endtask

  task automatic wait_done(input int base, input int lim, output int mx);
    mx = 0;
    for (int i = 0; i < lim && done_cnt == base; i++) begin
      if (busy && int'(round) > mx) mx = int'(round);
      tick();
    end
  endtask

  task automatic test_reset();
    fill_count(); kwb.kw_rdy = 1'b1; w_vld = 1'b1; rst = 1'b1;
    tick(); tick();
    h_run = 1'b1;
    tick();
    checks++; if ({kwb.kw_vld, kwb.kw_first, kwb.kw_last, kw_done, round_adv, run_err, busy} !== 7'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000000", {kwb.kw_vld, kwb.kw_first, kwb.kw_last, kw_done, round_adv, run_err, busy}); end
    checks++; if (kwb.kw !== '0 || round !== '0) begin
      failures++; $display("FAIL reset_kw_round got kw=%h round=%0d exp 0/0", kwb.kw, round); end
    rst = 1'b0; h_run = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_run_dropped got busy=%b exp=0", busy); end
  endtask

  task automatic test_mode512();
    int b = q_kw.size(), bd = done_cnt, ba = adv_cnt, t, n, mx;
    fill_count(); kwb.kw_rdy = 1'b1; w_vld = 1'b1;
    start(1'b1, t);
    wait_done(bd, 300, mx);
    n = q_kw.size() - b;
    checks++; if (n != 80) begin failures++; $display("FAIL m512_beats got=%0d exp=80", n); end
    for (int i = 0; i < n && i < 80; i++) begin
      checks++; if (q_kw[b+i] !== model(1'b1, i) || q_first[b+i] !== (i == 0) || q_last[b+i] !== (i == 79)) begin
        failures++; $display("FAIL m512_beat%0d got kw=%h f=%b l=%b exp kw=%h", i, q_kw[b+i], q_first[b+i], q_last[b+i], model(1'b1, i)); end
    end
    checks++; if (n > 0 && q_cyc[b] != t + 2) begin failures++; $display("FAIL m512_latency got=%0d exp=%0d", q_cyc[b] - t, 2); end
    checks++; if (done_cnt - bd != 1 || (n > 0 && done_cyc != q_cyc[b+n-1] + 1)) begin
      failures++; $display("FAIL m512_done got cnt=%0d cyc=%0d exp 1 at %0d", done_cnt - bd, done_cyc, n > 0 ? q_cyc[b+n-1] + 1 : -1); end
    checks++; if (busy !== 1'b0 || kw_done !== 1'b0) begin failures++; $display("FAIL m512_idle got busy=%b done=%b exp 0/0", busy, kw_done); end
    checks++; if (adv_cnt - ba != 80) begin failures++; $display("FAIL m512_adv got=%0d exp=80", adv_cnt - ba); end
  endtask

  task automatic test_mode256();
    int b = q_kw.size(), bd = done_cnt, t, n, mx;
    for (int i = 0; i < 128; i++) begin ktab[i] = 64'h1234_5678_FFFF_FFFF; wtab[i] = 64'h8765_4321_0000_0002; end
    kwb.kw_rdy = 1'b1; w_vld = 1'b1;
    start(1'b0, t);
    wait_done(bd, 300, mx);
    n = q_kw.size() - b;
    checks++; if (n != 64) begin failures++; $display("FAIL m256_beats got=%0d exp=64", n); end
    for (int i = 0; i < n && i < 64; i++) begin
      checks++; if (q_kw[b+i] !== 64'h1 || q_first[b+i] !== (i == 0) || q_last[b+i] !== (i == 63)) begin
        failures++; $display("FAIL m256_beat%0d got kw=%h f=%b l=%b exp kw=1", i, q_kw[b+i], q_first[b+i], q_last[b+i]); end
    end
    checks++; if (done_cnt - bd != 1 || (n > 0 && done_cyc != q_cyc[b+n-1] + 1)) begin
      failures++; $display("FAIL m256_done got cnt=%0d cyc=%0d", done_cnt - bd, done_cyc); end
    checks++; if (mx > 63) begin failures++; $display("FAIL m256_round_max got=%0d exp<=63", mx); end
  endtask

  task automatic test_stall_random();
    int b = q_kw.size(), bd = done_cnt, ba = adv_cnt, t, n, mx;
    fill_rand(); kwb.kw_rdy = 1'b1; vld_rand = 1'b1; rdy_tog = 1'b1;
    start(1'b1, t);
    wait_done(bd, 2000, mx);
    vld_rand = 1'b0; rdy_tog = 1'b0; w_vld = 1'b1; kwb.kw_rdy = 1'b1;
    n = q_kw.size() - b;
    checks++; if (n != 80) begin failures++; $display("FAIL rnd_beats got=%0d exp=80", n); end
    for (int i = 0; i < n && i < 80; i++) begin
      checks++; if (q_kw[b+i] !== model(1'b1, i)) begin
        failures++; $display("FAIL rnd_beat%0d got=%h exp=%h", i, q_kw[b+i], model(1'b1, i)); end
    end
    checks++; if (adv_cnt - ba != 80) begin failures++; $display("FAIL rnd_adv got=%0d exp=80", adv_cnt - ba); end
    checks++; if (done_cnt - bd != 1) begin failures++; $display("FAIL rnd_done got=%0d exp=1", done_cnt - bd); end
  endtask

  task automatic test_backpressure();
    int b = q_kw.size(), bd = done_cnt, t, n, mx;
    fill_count(); kwb.kw_rdy = 1'b1; w_vld = 1'b1;
    start(1'b1, t);
    for (int i = 0; i < 50 && round != 7'd6; i++) tick();
    kwb.kw_rdy = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      checks++; if (round !== 7'd7 || round_adv !== 1'b0 || kwb.kw_vld !== 1'b1 || kwb.kw !== 64'd6 || kwb.kw_first !== 1'b0 || kwb.kw_last !== 1'b0) begin
        failures++; $display("FAIL bp_hold%0d got round=%0d adv=%b vld=%b kw=%h exp 7/0/1/6", i, round, round_adv, kwb.kw_vld, kwb.kw); end
      tick();
    end
    kwb.kw_rdy = 1'b1;
    wait_done(bd, 300, mx);
    n = q_kw.size() - b;
    checks++; if (n != 80) begin failures++; $display("FAIL bp_beats got=%0d exp=80", n); end
    for (int i = 0; i < n && i < 80; i++) begin
      checks++; if (q_kw[b+i] !== 64'(i + 1)) begin failures++; $display("FAIL bp_beat%0d got=%h exp=%h", i, q_kw[b+i], 64'(i + 1)); end
    end
  endtask

  task automatic test_clear();
    int b, bd, t, n, mx;
    fill_count(); kwb.kw_rdy = 1'b1; w_vld = 1'b1;
    start(1'b1, t);
    for (int i = 0; i < 60 && round != 7'd30; i++) tick();
    h_clr = 1'b1;
    tick();
    h_clr = 1'b0;
    checks++; if (kwb.kw_vld !== 1'b0 || kwb.kw !== '0 || round !== '0 || busy !== 1'b0) begin
      failures++; $display("FAIL clr_state got vld=%b kw=%h round=%0d busy=%b exp 0", kwb.kw_vld, kwb.kw, round, busy); end
    bd = done_cnt;
    repeat (5) tick();
    checks++; if (done_cnt != bd || kwb.kw_vld !== 1'b0) begin failures++; $display("FAIL clr_no_done got done=%0d vld=%b exp 0/0", done_cnt - bd, kwb.kw_vld); end
    fill_rand(); b = q_kw.size();
    start(1'b0, t);
    wait_done(bd, 300, mx);
    n = q_kw.size() - b;
    checks++; if (n != 64 || done_cnt - bd != 1) begin failures++; $display("FAIL clr_rerun got beats=%0d done=%0d exp 64/1", n, done_cnt - bd); end
    for (int i = 0; i < n && i < 64; i++) begin
      checks++; if (q_kw[b+i] !== model(1'b0, i)) begin failures++; $display("FAIL clr_beat%0d got=%h exp=%h", i, q_kw[b+i], model(1'b0, i)); end
    end
  endtask

  task automatic test_run_err();
    int b = q_kw.size(), bd = done_cnt, be = err_cnt, t, n, mx;
    fill_count(); kwb.kw_rdy = 1'b1; w_vld = 1'b1;
    start(1'b1, t);
    for (int i = 0; i < 50 && round != 7'd10; i++) tick();
    h_run = 1'b1; h_mode = 1'b0;
    tick();
    h_run = 1'b0;
    wait_done(bd, 300, mx);
    n = q_kw.size() - b;
    checks++; if (err_cnt - be != 1) begin failures++; $display("FAIL err_pulse got=%0d exp=1", err_cnt - be); end
    checks++; if (n != 80 || done_cnt - bd != 1) begin failures++; $display("FAIL err_run got beats=%0d done=%0d exp 80/1", n, done_cnt - bd); end
    for (int i = 0; i < n && i < 80; i++) begin
      checks++; if (q_kw[b+i] !== 64'(i + 1)) begin failures++; $display("FAIL err_beat%0d got=%h exp=%h", i, q_kw[b+i], 64'(i + 1)); end
    end
    b = q_kw.size(); be = err_cnt;
    tick();
    h_clr = 1'b1; h_run = 1'b1; h_mode = 1'b1;
    tick();
    h_clr = 1'b0; h_run = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clr_run_busy got=%b exp=0", busy); end
    repeat (5) tick();
    checks++; if (q_kw.size() != b || busy !== 1'b0 || err_cnt != be) begin
      failures++; $display("FAIL clr_run_idle got beats=%0d busy=%b err=%0d exp 0/0/0", q_kw.size() - b, busy, err_cnt - be); end
  endtask

  initial begin
    test_reset();
    test_mode512();
    test_mode256();
    test_stall_random();
    test_backpressure();
    test_clear();
    test_run_err();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
